// File: rtl/winner_uart_reporter.sv
// winner_uart_reporter: formats each ensemble winner ID as ASCII ("NN\r\n")
// and writes it byte by byte into a UART-lite TX FIFO over AXI4-Lite,
// polling the status register before each byte.
// Optional build macro REPORT_SEQ_EN: prefixes each frame with an 8-bit
// hex sequence number and ':' ("SS:NN\r\n").
`timescale 1ns/1ps
module winner_uart_reporter #(
  parameter int unsigned N_CLASS      = 20,
  parameter logic [3:0]  TX_FIFO_ADDR = 4'h4,
  parameter logic [3:0]  STAT_ADDR    = 4'h8,
  parameter int unsigned TXFULL_BIT   = 3
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic        result_valid,
  input  logic [4:0]  winner_ID,
  output logic [3:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [3:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned ID_W  = 5;
  localparam int unsigned IDX_W = 3;
`ifdef REPORT_SEQ_EN
  localparam int unsigned N_BYTES = 7;
`else
  localparam int unsigned N_BYTES = 4;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
  localparam logic [IDX_W-1:0] TENS_IDX  = IDX_W'(N_BYTES - 4);
  localparam logic [IDX_W-1:0] UNITS_IDX = IDX_W'(N_BYTES - 3);
  localparam logic [IDX_W-1:0] CR_IDX    = IDX_W'(N_BYTES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_AR, S_POLL_R, S_WR, S_WR_B, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_frame_id, w_frame_id_nxt, r_pend_id, w_pend_id_nxt, w_start_id;
  logic              r_pend_full, w_pend_full_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
  logic              r_arvalid, w_arvalid_nxt, r_rready, w_rready_nxt;
  logic              r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt;
  logic              r_bready, w_bready_nxt, r_busy, w_busy_nxt;
  logic [3:0]        r_araddr, w_araddr_nxt, r_awaddr, w_awaddr_nxt;
  logic [3:0]        r_wstrb, w_wstrb_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [7:0]        r_drop_cnt, w_drop_cnt_nxt, r_err_cnt, w_err_cnt_nxt;
  logic              w_start, w_pend_take, w_err_evt;
  logic              w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic [1:0]        w_tens;
  logic [ID_W-1:0]   w_tens_x10;
  logic [3:0]        w_units;
  logic              w_id_ok;
  logic [7:0]        w_byte;
  logic              w_unused;
`ifdef REPORT_SEQ_EN
  logic [7:0]        r_seq_cnt, w_seq_cnt_nxt, r_frame_seq, w_frame_seq_nxt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction
`endif

  assign w_ar_hs  = r_arvalid & m_axi_arready;
  assign w_r_hs   = r_rready  & m_axi_rvalid;
  assign w_aw_hs  = r_awvalid & m_axi_awready;
  assign w_w_hs   = r_wvalid  & m_axi_wready;
  assign w_b_hs   = r_bready  & m_axi_bvalid;
  assign w_unused = ^m_axi_rdata;

  // Decimal digits of the current frame ID and the byte selected by r_idx
  always_comb begin
    w_tens     = 2'd0;
    w_tens_x10 = ID_W'(0);
    if (r_frame_id >= ID_W'(30))      begin w_tens = 2'd3; w_tens_x10 = ID_W'(30); end
    else if (r_frame_id >= ID_W'(20)) begin w_tens = 2'd2; w_tens_x10 = ID_W'(20); end
    else if (r_frame_id >= ID_W'(10)) begin w_tens = 2'd1; w_tens_x10 = ID_W'(10); end
    w_units = 4'(r_frame_id - w_tens_x10);
    w_id_ok = (32'(r_frame_id) < N_CLASS);
    w_byte  = 8'h0A;
    if (r_idx == TENS_IDX)       w_byte = w_id_ok ? (8'h30 + 8'(w_tens))  : 8'h3F;
    else if (r_idx == UNITS_IDX) w_byte = w_id_ok ? (8'h30 + 8'(w_units)) : 8'h3F;
    else if (r_idx == CR_IDX)    w_byte = 8'h0D;
`ifdef REPORT_SEQ_EN
    else if (r_idx == IDX_W'(0)) w_byte = hex_ascii(r_frame_seq[7:4]);
    else if (r_idx == IDX_W'(1)) w_byte = hex_ascii(r_frame_seq[3:0]);
    else if (r_idx == IDX_W'(2)) w_byte = 8'h3A;
`endif
  end

  // Next-state, capture/pending and registered-output next values
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_id_nxt  = r_frame_id;
    w_pend_id_nxt   = r_pend_id;
    w_pend_full_nxt = r_pend_full;
    w_idx_nxt       = r_idx;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_drop_cnt_nxt  = r_drop_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_araddr_nxt    = r_araddr;
    w_awaddr_nxt    = r_awaddr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_start         = 1'b0;
    w_start_id      = r_frame_id;
    w_pend_take     = 1'b0;
    w_err_evt       = 1'b0;
`ifdef REPORT_SEQ_EN
    w_seq_cnt_nxt   = r_seq_cnt;
    w_frame_seq_nxt = r_frame_seq;
`endif

    case (r_state)
      S_IDLE: begin
        if (r_pend_full) begin
          w_start = 1'b1; w_start_id = r_pend_id; w_pend_take = 1'b1;
        end else if (result_valid) begin
          w_start = 1'b1; w_start_id = winner_ID;
        end
      end
      S_POLL_AR: if (w_ar_hs) w_state_nxt = S_POLL_R;
      S_POLL_R: begin
        if (w_r_hs) begin
          if (m_axi_rresp != 2'b00) begin
            w_err_evt   = 1'b1;
            w_state_nxt = S_POLL_AR;
          end else if (m_axi_rdata[TXFULL_BIT]) begin
            w_state_nxt = S_POLL_AR;
          end else begin
            w_state_nxt   = S_WR;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
          end
        end
      end
      S_WR: begin
        w_aw_done_nxt = r_aw_done | w_aw_hs;
        w_w_done_nxt  = r_w_done  | w_w_hs;
        if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = S_WR_B;
      end
      S_WR_B: begin
        if (w_b_hs) begin
          w_err_evt = (m_axi_bresp != 2'b00);
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_POLL_AR;
          end
        end
      end
      S_DONE: begin
        if (r_pend_full) begin
          w_start = 1'b1; w_start_id = r_pend_id; w_pend_take = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_start) begin
      w_state_nxt    = S_POLL_AR;
      w_frame_id_nxt = w_start_id;
      w_idx_nxt      = IDX_W'(0);
`ifdef REPORT_SEQ_EN
      w_frame_seq_nxt = r_seq_cnt;
      w_seq_cnt_nxt   = r_seq_cnt + 8'd1;
`endif
    end

    // Results arriving while a frame is owed go to the 1-deep pending slot
    if (w_pend_take) w_pend_full_nxt = 1'b0;
    if (result_valid && (r_state != S_IDLE || r_pend_full)) begin
      w_pend_id_nxt   = winner_ID;
      w_pend_full_nxt = 1'b1;
      if (r_pend_full && !w_pend_take && r_drop_cnt != 8'hFF)
        w_drop_cnt_nxt = r_drop_cnt + 8'd1;
    end

    if (w_err_evt && r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;

    w_arvalid_nxt = (w_state_nxt == S_POLL_AR);
    w_rready_nxt  = (w_state_nxt == S_POLL_R);
    w_awvalid_nxt = (w_state_nxt == S_WR) && !w_aw_done_nxt;
    w_wvalid_nxt  = (w_state_nxt == S_WR) && !w_w_done_nxt;
    w_bready_nxt  = (w_state_nxt == S_WR_B);
    w_busy_nxt    = !(w_state_nxt == S_IDLE || w_state_nxt == S_DONE);
    if (w_state_nxt == S_POLL_AR) w_araddr_nxt = STAT_ADDR;
    if (r_state == S_POLL_R && w_state_nxt == S_WR) begin
      w_awaddr_nxt = TX_FIFO_ADDR;
      w_wdata_nxt  = {24'b0, w_byte};
      w_wstrb_nxt  = 4'b0001;
    end
  end

  // State and output registers
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_frame_id  <= '0;
      r_pend_id   <= '0;
      r_pend_full <= 1'b0;
      r_idx       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_araddr    <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
`ifdef REPORT_SEQ_EN
      r_seq_cnt   <= '0;
      r_frame_seq <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_frame_id  <= w_frame_id_nxt;
      r_pend_id   <= w_pend_id_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_idx       <= w_idx_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_busy      <= w_busy_nxt;
      r_araddr    <= w_araddr_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
`ifdef REPORT_SEQ_EN
      r_seq_cnt   <= w_seq_cnt_nxt;
      r_frame_seq <= w_frame_seq_nxt;
`endif
    end
  end

  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign busy          = r_busy;
  assign drop_cnt      = r_drop_cnt;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_winner_uart_reporter.sv
// Scoreboard bench for winner_uart_reporter: directed IDs push expected
// bytes; a monitor pops and compares on every W-channel handshake.
`timescale 1ns/1ps
module tb_winner_uart_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        result_valid;
  logic [4:0]  winner_ID;
  logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready, busy;
  logic [7:0]  drop_cnt, err_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          ar_count = 0;
  int          byte_num = 0;
  int          aw_delay = 0;
  int          err_byte = -1;
  int          full_byte = -1;
  logic        seen_split = 1'b0;
  logic [7:0]  tb_seq = 8'h00;

  always #5 clk = ~clk;

  winner_uart_reporter dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .result_valid(result_valid), .winner_ID(winner_ID),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef REPORT_SEQ_EN
  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
  endfunction
`endif

  // Expected frame: optional "SS:" prefix, then two digit bytes, CR, LF
  task automatic push_frame(input logic [7:0] d_tens, input logic [7:0] d_units);
`ifdef REPORT_SEQ_EN
    exp_q.push_back(hex_ch(tb_seq[7:4]));
    exp_q.push_back(hex_ch(tb_seq[3:0]));
    exp_q.push_back(8'h3A);
    tb_seq = tb_seq + 8'd1;
`endif
    exp_q.push_back(d_tens);
    exp_q.push_back(d_units);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send(input logic [4:0] id);
    @(negedge clk);
    result_valid = 1'b1;
    winner_ID    = id;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!busy && exp_q.size() == 0 && !m_axi_bvalid) quiet++;
      else quiet = 0;
    end
    check({name, "_done"}, 32'(quiet >= 4), 32'd1);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  // AXI4-Lite slave: decides readies at negedge, acts on handshakes one cycle later
  initial begin : slave
    logic hs_ar, hs_r, hs_aw, hs_w, hs_b, aw_got, w_got;
    int aw_wait, full_cnt;
    hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0; aw_got = 0; w_got = 0;
    aw_wait = 0; full_cnt = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0; aw_got = 0; w_got = 0;
        aw_wait = 0; full_cnt = 0; byte_num = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bvalid = 0;
        continue;
      end
      if (hs_r) m_axi_rvalid = 0;
      if (hs_b) m_axi_bvalid = 0;
      if (hs_ar) begin
        ar_count++;
        m_axi_rvalid = 1; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
        if (byte_num == full_byte && full_cnt < 3) begin
          m_axi_rdata = 32'h8;
          full_cnt++;
        end
      end
      if (hs_aw) aw_got = 1;
      if (hs_w)  w_got  = 1;
      if (aw_got && w_got) begin
        m_axi_bvalid = 1;
        m_axi_bresp  = (byte_num == err_byte) ? 2'b10 : 2'b00;
        byte_num++;
        aw_got = 0; w_got = 0;
      end
      m_axi_arready = 1;
      m_axi_wready  = 1;
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        m_axi_awready = 0;
        aw_wait = 0;
      end
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid  && m_axi_rready;
      hs_aw = m_axi_awvalid && m_axi_awready;
      hs_w  = m_axi_wvalid  && m_axi_wready;
      hs_b  = m_axi_bvalid  && m_axi_bready;
    end
  end

  // Monitor: compares every presented write/read against the scoreboard
  initial begin : monitor
    logic prev_aw, prev_w;
    logic [7:0] e;
    prev_aw = 0; prev_w = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin prev_aw = 0; prev_w = 0; continue; end
      if (prev_w)  check("wvalid_drop", 32'(m_axi_wvalid), 32'd0);
      if (prev_aw) check("awvalid_drop", 32'(m_axi_awvalid), 32'd0);
      if (m_axi_awvalid && !m_axi_wvalid) seen_split = 1'b1;
      prev_w  = m_axi_wvalid  && m_axi_wready;
      prev_aw = m_axi_awvalid && m_axi_awready;
      if (m_axi_arvalid && m_axi_arready) check("araddr", 32'(m_axi_araddr), 32'h8);
      if (m_axi_awvalid && m_axi_awready) check("awaddr", 32'(m_axi_awaddr), 32'h4);
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got byte 0x%0h, expected none", m_axi_wdata[7:0]);
        end else begin
          e = exp_q.pop_front();
          check("wdata", m_axi_wdata, {24'b0, e});
          check("wstrb", 32'(m_axi_wstrb), 32'h1);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ar0;
    result_valid = 0;
    winner_ID    = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valids", 32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                             m_axi_rready, m_axi_bready, busy}), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
    check("rst_araddr", 32'(m_axi_araddr), 32'd0);
    check("rst_wdata", m_axi_wdata, 32'd0);
    check("rst_wstrb", 32'(m_axi_wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // ID 7 -> "07\r\n", one status read per byte
    ar0 = ar_count;
    push_frame(8'h30, 8'h37);
    send(5'd7);
    wait_idle("id7");
    check("id7_reads", 32'(ar_count - ar0), 32'd4);

    // Out-of-range and boundary IDs
    push_frame(8'h3F, 8'h3F);
    send(5'd25);
    wait_idle("id25");
    push_frame(8'h31, 8'h39);
    send(5'd19);
    wait_idle("id19");
    push_frame(8'h3F, 8'h3F);
    send(5'd20);
    wait_idle("id20");

    // TX FIFO full for 3 polls before the second byte
    ar0 = ar_count;
    full_byte = byte_num + 1;
    push_frame(8'h31, 8'h32);
    send(5'd12);
    wait_idle("txfull");
    check("txfull_reads", 32'(ar_count - ar0), 32'd7);
    full_byte = -1;

    // 3, 4, 5 while busy: 4 is overwritten by 5
    push_frame(8'h30, 8'h33);
    push_frame(8'h30, 8'h35);
    send(5'd3);
    repeat (3) @(negedge clk);
    send(5'd4);
    repeat (3) @(negedge clk);
    send(5'd5);
    wait_idle("drop");
    check("drop_cnt", 32'(drop_cnt), 32'd1);
    check("drop_err_cnt", 32'(err_cnt), 32'd0);

    // Slow awready plus one SLVERR write response
    aw_delay = 2;
    err_byte = byte_num + 2;
    push_frame(8'h31, 8'h31);
    send(5'd11);
    wait_idle("slow_aw");
    check("err_cnt", 32'(err_cnt), 32'd1);
    check("aw_w_split", 32'(seen_split), 32'd1);
    aw_delay = 0;
    err_byte = -1;

    // Reset in the middle of a frame
    push_frame(8'h30, 8'h39);
    send(5'd9);
    repeat (8) @(negedge clk);
    #3;
    rst_n = 0;
    #1;
    check("midrst_valids", 32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                                m_axi_rready, m_axi_bready, busy}), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    exp_q.delete();
    tb_seq = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("midrst_quiet", 32'(busy), 32'd0);

    // Fresh frames after reset (sequence restarts at 00)
    push_frame(8'h30, 8'h30);
    send(5'd0);
    wait_idle("post_rst0");
    push_frame(8'h31, 8'h32);
    send(5'd12);
    wait_idle("post_rst12");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
